// File: rtl/fetch_unit_pkg.sv
// Shared types, constants and helpers for the instruction-fetch stage.
package fetch_unit_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned JIDX_W = 26;

  localparam logic [XLEN-1:0] NOP    = 32'h0000_0000;
  localparam logic [XLEN-1:0] PC_INC = 32'd4;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } fetch_state_e;

  // IF/ID payload handed to decode.
  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
  } ifid_t;

  // Jump target: region bits from the delay-slot PC, index field word-aligned.
  function automatic logic [XLEN-1:0] jump_pc(input logic [XLEN-1:0]   pc_plus4,
                                               input logic [JIDX_W-1:0] idx);
    return {pc_plus4[31:28], idx, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_if_id_reg.sv
// IF/ID pipeline register: load a fetched word, insert a bubble, or hold.
module if_id_reg
  import fetch_unit_pkg::*;
(
  input  logic  clock,
  input  logic  reset_n,
  input  logic  load_i,
  input  logic  bubble_i,
  input  ifid_t data_i,
  output ifid_t data_o,
  output logic  valid_o
);

  ifid_t data_q, data_d;
  logic  valid_q, valid_d;

  // Bubble beats load; PC fields are kept on a bubble so jump region bits stay meaningful.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (bubble_i) begin
      data_d.instr = NOP;
      valid_d      = 1'b0;
    end else if (load_i) begin
      data_d  = data_i;
      valid_d = 1'b1;
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, handles stall, redirect and end-of-program.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned MEM_DEPTH = 1024
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic [31:0] i_addr,
  input  logic [31:0] i_data,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [25:0] jump_target,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4,
  output logic        fetch_done,
  output logic        misalign_err
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            pend_vld_q, pend_vld_d;
  logic [XLEN-1:0] pend_tgt_q, pend_tgt_d;
  logic            done_q, done_d;
  logic            misalign_q, misalign_d;

  logic            ifid_load, ifid_bubble;
  ifid_t           ifid_in, ifid_out;
  logic            ifid_valid;

  logic [XLEN-1:0] pc_next_seq;
  logic [XLEN-1:0] jmp_tgt;
  logic [XLEN-1:0] br_tgt;
  logic            br_misalign;
  logic            out_of_range;

  // Redirect targets, sequential PC and range check.
  always_comb begin
    pc_next_seq  = pc_q + PC_INC;
    jmp_tgt      = jump_pc(ifid_out.pc_plus4, jump_target);
    br_tgt       = {branch_target[31:2], 2'b00};
    br_misalign  = |branch_target[1:0];
    out_of_range = {2'b00, pc_q[31:2]} >= 32'(MEM_DEPTH);
  end

  // Next-state, next-PC and IF/ID control.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    pend_vld_d  = pend_vld_q;
    pend_tgt_d  = pend_tgt_q;
    done_d      = done_q;
    misalign_d  = misalign_q;
    ifid_load   = 1'b0;
    ifid_bubble = 1'b0;
    ifid_in     = '{instr: i_data, pc: pc_q, pc_plus4: pc_next_seq};

    unique case (state_q)
      ST_BOOT: begin
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (stall) begin
          if (jump) begin
            pend_vld_d = 1'b1;
            pend_tgt_d = jmp_tgt;
          end else if (branch_taken) begin
            pend_vld_d = 1'b1;
            pend_tgt_d = br_tgt;
            misalign_d = misalign_q | br_misalign;
          end
        end else if (jump) begin
          pc_d        = jmp_tgt;
          ifid_bubble = 1'b1;
          pend_vld_d  = 1'b0;
        end else if (branch_taken) begin
          pc_d        = br_tgt;
          ifid_bubble = 1'b1;
          pend_vld_d  = 1'b0;
          misalign_d  = misalign_q | br_misalign;
        end else if (pend_vld_q) begin
          pc_d        = pend_tgt_q;
          ifid_bubble = 1'b1;
          pend_vld_d  = 1'b0;
        end else if (out_of_range) begin
          state_d     = ST_DONE;
          done_d      = 1'b1;
          ifid_bubble = 1'b1;
        end else begin
          ifid_load = 1'b1;
          pc_d      = pc_next_seq;
        end
      end
      ST_DONE: begin
        done_d      = 1'b1;
        ifid_bubble = 1'b1;
      end
      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  // Control state registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q    <= ST_BOOT;
      pc_q       <= RESET_PC;
      pend_vld_q <= 1'b0;
      pend_tgt_q <= '0;
      done_q     <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_vld_q <= pend_vld_d;
      pend_tgt_q <= pend_tgt_d;
      done_q     <= done_d;
      misalign_q <= misalign_d;
    end
  end

  if_id_reg u_if_id (
    .clock    (clock),
    .reset_n  (reset_n),
    .load_i   (ifid_load),
    .bubble_i (ifid_bubble),
    .data_i   (ifid_in),
    .data_o   (ifid_out),
    .valid_o  (ifid_valid)
  );

  assign i_addr       = {2'b00, pc_q[31:2]};
  assign if_valid     = ifid_valid;
  assign if_instr     = ifid_out.instr;
  assign if_pc        = ifid_out.pc;
  assign if_pc_plus4  = ifid_out.pc_plus4;
  assign fetch_done   = done_q;
  assign misalign_err = misalign_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a full-depth instance and a 4-word instance.
module tb_fetch_unit;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;

  logic        clock;
  logic        reset_n, stall, branch_taken, jump;
  logic [31:0] branch_target, i_addr, i_data;
  logic [25:0] jump_target;
  logic        if_valid, fetch_done, misalign_err;
  logic [31:0] if_instr, if_pc, if_pc_plus4;

  logic        s_reset_n, s_stall, s_branch_taken, s_jump;
  logic [31:0] s_branch_target, s_i_addr, s_i_data;
  logic [25:0] s_jump_target;
  logic        s_if_valid, s_fetch_done, s_misalign_err;
  logic [31:0] s_if_instr, s_if_pc, s_if_pc_plus4;

  logic [31:0] mem [0:1023];
  exp_t        q[$];
  exp_t        sq[$];
  int          checks = 0;
  int          errors = 0;

  fetch_unit #(.RESET_PC(32'h0), .MEM_DEPTH(1024)) dut (
    .clock(clock), .reset_n(reset_n), .i_addr(i_addr), .i_data(i_data),
    .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target), .if_valid(if_valid),
    .if_instr(if_instr), .if_pc(if_pc), .if_pc_plus4(if_pc_plus4),
    .fetch_done(fetch_done), .misalign_err(misalign_err)
  );

  fetch_unit #(.RESET_PC(32'h0), .MEM_DEPTH(4)) dut_s (
    .clock(clock), .reset_n(s_reset_n), .i_addr(s_i_addr), .i_data(s_i_data),
    .stall(s_stall), .branch_taken(s_branch_taken), .branch_target(s_branch_target),
    .jump(s_jump), .jump_target(s_jump_target), .if_valid(s_if_valid),
    .if_instr(s_if_instr), .if_pc(s_if_pc), .if_pc_plus4(s_if_pc_plus4),
    .fetch_done(s_fetch_done), .misalign_err(s_misalign_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Combinational instruction memory: word k holds 32'hC0DE_0000 + k.
  initial for (int k = 0; k < 1024; k++) mem[k] = 32'hC0DE_0000 + 32'(k);
  assign i_data   = (i_addr   < 32'd1024) ? mem[i_addr[9:0]]   : 32'h0;
  assign s_i_data = (s_i_addr < 32'd1024) ? mem[s_i_addr[9:0]] : 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [31:0] instr, input logic [31:0] pc);
    exp_t e;
    e.instr = instr;
    e.pc    = pc;
    q.push_back(e);
  endtask

  task automatic spush(input logic [31:0] instr, input logic [31:0] pc);
    exp_t e;
    e.instr = instr;
    e.pc    = pc;
    sq.push_back(e);
  endtask

  // Monitor: an IF/ID word is consumed by decode when valid and not stalled.
  always @(negedge clock) begin
    if (if_valid === 1'b1 && stall === 1'b0) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL main_unexpected: got instr %h pc %h expected none", if_instr, if_pc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("main_instr", if_instr, e.instr);
        chk("main_pc", if_pc, e.pc);
        chk("main_pc_plus4", if_pc_plus4, e.pc + 32'd4);
      end
    end
  end

  always @(negedge clock) begin
    if (s_if_valid === 1'b1 && s_stall === 1'b0) begin
      if (sq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL small_unexpected: got instr %h pc %h expected none", s_if_instr, s_if_pc);
      end else begin
        exp_t e;
        e = sq.pop_front();
        chk("small_instr", s_if_instr, e.instr);
        chk("small_pc", s_if_pc, e.pc);
        chk("small_pc_plus4", s_if_pc_plus4, e.pc + 32'd4);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; stall = 1'b0; branch_taken = 1'b0; jump = 1'b0;
    branch_target = '0; jump_target = '0;
    s_reset_n = 1'b0; s_stall = 1'b0; s_branch_taken = 1'b0; s_jump = 1'b0;
    s_branch_target = '0; s_jump_target = '0;

    // Reset state
    cyc();
    chk("rst_valid", 32'(if_valid), 32'd0);
    chk("rst_instr", if_instr, 32'h0);
    chk("rst_pc", if_pc, 32'h0);
    chk("rst_pc4", if_pc_plus4, 32'h0);
    chk("rst_done", 32'(fetch_done), 32'd0);
    chk("rst_mis", 32'(misalign_err), 32'd0);
    chk("rst_addr", i_addr, 32'd0);

    // BOOT holds PC for one cycle
    reset_n = 1'b1;
    cyc();
    chk("boot_addr", i_addr, 32'd0);
    chk("boot_valid", 32'(if_valid), 32'd0);

    // Sequential fetch of A, B
    push(32'hC0DE_0000, 32'h0);
    cyc();
    chk("seq_addr1", i_addr, 32'd1);
    push(32'hC0DE_0001, 32'h4);
    cyc();
    chk("seq_addr2", i_addr, 32'd2);

    // Stall two cycles holding B
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cyc();
      chk("stall_addr", i_addr, 32'd2);
      chk("stall_instr", if_instr, 32'hC0DE_0001);
      chk("stall_pc", if_pc, 32'h4);
    end
    stall = 1'b0;
    push(32'hC0DE_0002, 32'h8);
    cyc();
    chk("release_addr", i_addr, 32'd3);

    // Taken branch to 0x40: one bubble then mem[16]
    branch_taken = 1'b1; branch_target = 32'h40;
    cyc();
    chk("br_addr", i_addr, 32'd16);
    chk("br_bubble_valid", 32'(if_valid), 32'd0);
    chk("br_bubble_instr", if_instr, 32'h0);
    branch_taken = 1'b0;
    push(32'hC0DE_0010, 32'h40);
    cyc();
    chk("br_next_addr", i_addr, 32'd17);

    // Jump then branch during stall: branch overwrites pending jump
    stall = 1'b1; jump = 1'b1; jump_target = 26'h20;
    cyc();
    chk("pend_j_addr", i_addr, 32'd17);
    jump = 1'b0; branch_taken = 1'b1; branch_target = 32'h100;
    cyc();
    chk("pend_b_addr", i_addr, 32'd17);
    branch_taken = 1'b0; stall = 1'b0;
    cyc();
    chk("pend_rel_addr", i_addr, 32'h40);
    chk("pend_rel_valid", 32'(if_valid), 32'd0);
    push(32'hC0DE_0040, 32'h100);
    cyc();
    chk("pend_next_addr", i_addr, 32'h41);

    // Unstalled jump: region from if_pc_plus4 (0x104), index 8 -> 0x20
    jump = 1'b1; jump_target = 26'h8;
    cyc();
    chk("jmp_addr", i_addr, 32'd8);
    chk("jmp_bubble", 32'(if_valid), 32'd0);
    jump = 1'b0;
    push(32'hC0DE_0008, 32'h20);
    cyc();

    // Misaligned branch target 0x42 -> pc 0x40, sticky error
    branch_taken = 1'b1; branch_target = 32'h42;
    cyc();
    chk("mis_addr", i_addr, 32'd16);
    chk("mis_err", 32'(misalign_err), 32'd1);
    branch_taken = 1'b0;
    push(32'hC0DE_0010, 32'h40);
    cyc();
    push(32'hC0DE_0011, 32'h44);
    cyc();
    chk("mis_sticky", 32'(misalign_err), 32'd1);

    // Pending jump then reset: reset clears pending and misalign
    stall = 1'b1; jump = 1'b1; jump_target = 26'h30;
    cyc();
    chk("prst_addr", i_addr, 32'h12);
    reset_n = 1'b0; stall = 1'b0; jump = 1'b0;
    cyc();
    chk("prst_mis", 32'(misalign_err), 32'd0);
    chk("prst_addr0", i_addr, 32'd0);
    chk("prst_valid", 32'(if_valid), 32'd0);
    reset_n = 1'b1;
    cyc();
    chk("prst_boot_addr", i_addr, 32'd0);
    push(32'hC0DE_0000, 32'h0);
    cyc();
    chk("prst_no_pending", i_addr, 32'd1);
    reset_n = 1'b0;
    cyc();

    // 4-word memory: fetch A..D, then halt
    s_reset_n = 1'b1;
    cyc();
    chk("s_boot_addr", s_i_addr, 32'd0);
    spush(32'hC0DE_0000, 32'h0);
    cyc();
    spush(32'hC0DE_0001, 32'h4);
    cyc();
    spush(32'hC0DE_0002, 32'h8);
    cyc();
    spush(32'hC0DE_0003, 32'hC);
    cyc();
    chk("s_addr_d", s_i_addr, 32'd4);
    cyc();
    chk("s_done", 32'(s_fetch_done), 32'd1);
    chk("s_done_valid", 32'(s_if_valid), 32'd0);
    for (int i = 0; i < 10; i++) begin
      s_stall = 1'(i % 2); s_jump = 1'(i % 3 == 0);
      s_branch_taken = 1'b1; s_branch_target = 32'h3;
      cyc();
      chk("s_hold_done", 32'(s_fetch_done), 32'd1);
      chk("s_hold_valid", 32'(s_if_valid), 32'd0);
      chk("s_hold_addr", s_i_addr, 32'd4);
      chk("s_hold_mis", 32'(s_misalign_err), 32'd0);
    end
    s_stall = 1'b0; s_jump = 1'b0; s_branch_taken = 1'b0; s_branch_target = '0;
    s_reset_n = 1'b0;
    cyc();
    chk("s_rst_done", 32'(s_fetch_done), 32'd0);
    chk("s_rst_addr", s_i_addr, 32'd0);
    s_reset_n = 1'b1;
    cyc();
    chk("s_boot2_addr", s_i_addr, 32'd0);
    chk("s_boot2_valid", 32'(s_if_valid), 32'd0);
    chk("s_boot2_done", 32'(s_fetch_done), 32'd0);
    s_reset_n = 1'b0;
    cyc();
    @(negedge clock);

    chk("main_queue_left", 32'(q.size()), 32'd0);
    chk("small_queue_left", 32'(sq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
